// File: rtl/pwm_multi.sv
// pwm_multi: N-channel PWM generator that shares one period counter.
// It has a programmable prescaler and an edge-aligned or center-aligned
// counting mode. Channel levels are double-buffered: new levels wait in
// a pending register and are applied only at a period boundary, or at
// once while the block is stopped. The out and sync outputs are
// registered, so they lag the counter state by one clock.
module pwm_multi #(
    parameter int C_CLK_FRQ        = 100000000,
    parameter int C_LEVEL_WIDTH    = 8,
    parameter int C_CHANNELS       = 4,
    parameter int C_PRESCALE_WIDTH = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                enable,
    input  logic                                mode,
    input  logic [C_PRESCALE_WIDTH-1:0]         prescale,
    input  logic [C_CHANNELS*C_LEVEL_WIDTH-1:0] level,
    input  logic                                load,
    output logic [C_CHANNELS-1:0]               out,
    output logic                                sync,
    output logic                                pend
);

    localparam int W = C_LEVEL_WIDTH;
    localparam int N = C_CHANNELS;
    localparam int P = C_PRESCALE_WIDTH;

    // Last counter value of a sweep, M = 2^W - 2.
    localparam logic [W-1:0] CNT_MAX = ~(W'(1'b1));

    // The clock frequency has no effect on the logic. An invalid
    // configuration elaborates this empty marker block.
    if (C_CLK_FRQ <= 0 || C_CHANNELS < 1 || C_CHANNELS > 32) begin : g_param_out_of_range
    end

    typedef enum logic {
        ST_UP   = 1'b0,
        ST_DOWN = 1'b1
    } dir_e;

    dir_e               state_r, state_s;
    logic [P-1:0]       psc_r, psc_s;
    logic [W-1:0]       cnt_r, cnt_s;
    logic [N*W-1:0]     act_r, act_s;
    logic [N*W-1:0]     pending_r, pending_s;
    logic               pend_r, pend_s;
    logic               mode_act_r, mode_act_s;
    logic [P-1:0]       prescale_act_r, prescale_act_s;
    logic [N-1:0]       out_r, out_s;
    logic               sync_r, sync_s;
    logic               tick_s;
    logic               at_last_s;
    logic               boundary_s;
    logic               xfer_s;

    // Compute the next state: prescaler, counter sweep, double buffer and outputs.
    always_comb begin
        state_s        = state_r;
        psc_s          = psc_r;
        cnt_s          = cnt_r;
        act_s          = act_r;
        pending_s      = pending_r;
        pend_s         = pend_r;
        mode_act_s     = mode_act_r;
        prescale_act_s = prescale_act_r;
        out_s          = {N{1'b0}};
        sync_s         = 1'b0;

        tick_s = (psc_r == prescale_act_r);
        if (mode_act_r) begin
            at_last_s = (state_r == ST_DOWN) && (cnt_r == {W{1'b0}});
        end else begin
            at_last_s = (cnt_r == CNT_MAX);
        end
        boundary_s = enable && tick_s && at_last_s;
        // Pending levels are applied at a boundary, or at once while stopped.
        xfer_s = pend_r && (boundary_s || !enable);

        if (!enable) begin
            psc_s          = {P{1'b0}};
            cnt_s          = {W{1'b0}};
            state_s        = ST_UP;
            mode_act_s     = mode;
            prescale_act_s = prescale;
        end else if (tick_s) begin
            psc_s = {P{1'b0}};
            if (boundary_s) begin
                cnt_s          = {W{1'b0}};
                state_s        = ST_UP;
                mode_act_s     = mode;
                prescale_act_s = prescale;
            end else begin
                case (state_r)
                    ST_UP: begin
                        // Center mode holds M for one extra tick before it counts down.
                        if (mode_act_r && (cnt_r == CNT_MAX)) begin
                            state_s = ST_DOWN;
                        end else begin
                            cnt_s = cnt_r + W'(1'b1);
                        end
                    end
                    ST_DOWN: begin
                        // The 0-dwell is the boundary case above, so this branch is defensive.
                        if (cnt_r == {W{1'b0}}) begin
                            state_s = ST_UP;
                        end else begin
                            cnt_s = cnt_r - W'(1'b1);
                        end
                    end
                    default: begin
                        state_s = ST_UP;
                        cnt_s   = {W{1'b0}};
                    end
                endcase
            end
        end else begin
            psc_s = psc_r + P'(1'b1);
        end

        if (xfer_s) begin
            act_s = pending_r;
        end else begin
            act_s = act_r;
        end

        // A load that coincides with a transfer keeps pend set for the new value.
        if (load) begin
            pending_s = level;
            pend_s    = 1'b1;
        end else if (xfer_s) begin
            pend_s = 1'b0;
        end else begin
            pend_s = pend_r;
        end

        for (int k = 0; k < N; k++) begin
            out_s[k] = enable && (cnt_r < act_r[k*W +: W]);
        end
        // Only the first clock of a period has the state 0/UP/psc=0.
        sync_s = enable && (psc_r == {P{1'b0}}) && (cnt_r == {W{1'b0}}) && (state_r == ST_UP);
    end

    // State and output registers; reset overrides every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_UP;
            psc_r          <= {P{1'b0}};
            cnt_r          <= {W{1'b0}};
            act_r          <= {(N*W){1'b0}};
            pending_r      <= {(N*W){1'b0}};
            pend_r         <= 1'b0;
            mode_act_r     <= 1'b0;
            prescale_act_r <= {P{1'b0}};
            out_r          <= {N{1'b0}};
            sync_r         <= 1'b0;
        end else begin
            state_r        <= state_s;
            psc_r          <= psc_s;
            cnt_r          <= cnt_s;
            act_r          <= act_s;
            pending_r      <= pending_s;
            pend_r         <= pend_s;
            mode_act_r     <= mode_act_s;
            prescale_act_r <= prescale_act_s;
            out_r          <= out_s;
            sync_r         <= sync_s;
        end
    end

    assign out  = out_r;
    assign sync = sync_r;
    assign pend = pend_r;

endmodule

// File: tb/tb_pwm_multi.sv
// Directed testbench for pwm_multi with W=8, N=2 and P=8.
// Outputs are sampled on the falling clock edge.
module tb_pwm_multi;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        mode;
    logic [7:0]  prescale;
    logic [15:0] level;
    logic        load;
    logic [1:0]  out;
    logic        sync;
    logic        pend;

    int checks;
    int errors;

    int   len, hi0, hi1, first_low;
    logic last0, pend_prev, pend_last;
    logic ok;

    pwm_multi #(
        .C_CLK_FRQ(100000000),
        .C_LEVEL_WIDTH(8),
        .C_CHANNELS(2),
        .C_PRESCALE_WIDTH(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .mode(mode),
        .prescale(prescale),
        .level(level),
        .load(load),
        .out(out),
        .sync(sync),
        .pend(pend)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stop the run if it exceeds the time limit.
    initial begin
        #2000000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait, with a cycle limit, until a sample shows sync high.
    task automatic wait_sync(output logic found);
        found = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (sync) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    // Measure one period, starting at a sync sample and ending at the next one.
    // A load pulse is driven after sample index la and after sample index lb.
    task automatic meas(input int la, input logic [15:0] lva,
                        input int lb, input logic [15:0] lvb,
                        output int n, output int h0, output int h1,
                        output int fl, output logic l0,
                        output logic pp, output logic pl);
        n = 0; h0 = 0; h1 = 0; fl = -1; l0 = 1'b0; pp = 1'b0; pl = 1'b0;
        do begin
            if (out[0]) h0++;
            else if (fl < 0) fl = n;
            if (out[1]) h1++;
            l0 = out[0];
            pp = pl;
            pl = pend;
            if (n == la) begin
                level = lva; load = 1'b1;
            end else if (n == lb) begin
                level = lvb; load = 1'b1;
            end else begin
                load = 1'b0;
            end
            n++;
            @(negedge clk);
        end while (!sync && n < 4000);
        load = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; enable = 1'b1; load = 1'b1; mode = 1'b0;
        prescale = 8'd0; level = {8'd200, 8'd100};

        // Hold reset for 3 clocks with enable and load active.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_out", 32'(out), 32'd0);
            chk("rst_sync", 32'(sync), 32'd0);
            chk("rst_pend", 32'(pend), 32'd0);
        end
        rst = 1'b0; load = 1'b0; enable = 1'b0;
        step(1);
        chk("post_rst_pend", 32'(pend), 32'd0);
        chk("post_rst_out", 32'(out), 32'd0);

        // Load while stopped: pend rises, then clears on the next clock.
        level = {8'd255, 8'd64}; load = 1'b1;
        step(1);
        chk("load_pend_hi", 32'(pend), 32'd1);
        load = 1'b0;
        step(1);
        chk("dis_xfer_pend_lo", 32'(pend), 32'd0);

        // Edge mode, levels 64 and 255.
        enable = 1'b1;
        wait_sync(ok);
        chk("first_sync", 32'(ok), 32'd1);
        meas(-1, 16'd0, -1, 16'd0, len, hi0, hi1, first_low, last0, pend_prev, pend_last);
        chk("edge_len", len, 32'd255);
        chk("edge_hi0", hi0, 32'd64);
        chk("edge_first_low", first_low, 32'd64);
        chk("edge_hi1_full", hi1, 32'd255);

        // Double buffering: load 128 (ch1=0) at sample index 100.
        meas(100, {8'd0, 8'd128}, -1, 16'd0, len, hi0, hi1, first_low, last0, pend_prev, pend_last);
        chk("dbuf_len", len, 32'd255);
        chk("dbuf_cur_hi0", hi0, 32'd64);
        chk("dbuf_cur_hi1", hi1, 32'd255);
        chk("dbuf_pend_before", 32'(pend_prev), 32'd1);
        chk("dbuf_pend_fall", 32'(pend_last), 32'd0);

        // New levels apply. A mode change here waits for the boundary.
        mode = 1'b1;
        meas(10, {8'd255, 8'd64}, -1, 16'd0, len, hi0, hi1, first_low, last0, pend_prev, pend_last);
        chk("dbuf_next_len", len, 32'd255);
        chk("dbuf_next_hi0", hi0, 32'd128);
        chk("dbuf_next_first_low", first_low, 32'd128);
        chk("zero_level_hi1", hi1, 32'd0);

        // Center mode at level 64. Prescale and mode change mid-period.
        mode = 1'b0; prescale = 8'd3;
        meas(5, {8'd255, 8'd10}, -1, 16'd0, len, hi0, hi1, first_low, last0, pend_prev, pend_last);
        chk("ctr_len", len, 32'd510);
        chk("ctr_hi0", hi0, 32'd128);
        chk("ctr_first_low", first_low, 32'd64);
        chk("ctr_last_high", 32'(last0), 32'd1);
        chk("ctr_hi1", hi1, 32'd510);

        // Prescale 3, edge mode, level 10.
        meas(-1, 16'd0, -1, 16'd0, len, hi0, hi1, first_low, last0, pend_prev, pend_last);
        chk("psc_len", len, 32'd1020);
        chk("psc_hi0", hi0, 32'd40);
        chk("psc_first_low", first_low, 32'd40);
        prescale = 8'd0;
        meas(-1, 16'd0, -1, 16'd0, len, hi0, hi1, first_low, last0, pend_prev, pend_last);
        chk("psc_hold_len", len, 32'd1020);
        chk("psc_hold_hi0", hi0, 32'd40);

        // Load 32 mid-period, then load 96 on the boundary clock.
        meas(20, {8'd255, 8'd32}, 253, {8'd255, 8'd96}, len, hi0, hi1, first_low, last0, pend_prev, pend_last);
        chk("coin_len", len, 32'd255);
        chk("coin_hi0", hi0, 32'd10);
        chk("coin_pend_keep", 32'(pend_last), 32'd1);
        meas(-1, 16'd0, -1, 16'd0, len, hi0, hi1, first_low, last0, pend_prev, pend_last);
        chk("coin_old_hi0", hi0, 32'd32);
        chk("coin_old_pend_prev", 32'(pend_prev), 32'd1);
        chk("coin_old_pend_fall", 32'(pend_last), 32'd0);
        meas(-1, 16'd0, -1, 16'd0, len, hi0, hi1, first_low, last0, pend_prev, pend_last);
        chk("coin_new_hi0", hi0, 32'd96);

        // Disable mid-pulse, load while stopped, then re-enable.
        step(50);
        chk("pre_dis_out0", 32'(out[0]), 32'd1);
        enable = 1'b0;
        step(1);
        chk("dis_out", 32'(out), 32'd0);
        chk("dis_sync", 32'(sync), 32'd0);
        step(5);
        chk("dis_out_hold", 32'(out), 32'd0);
        level = {8'd255, 8'd200}; load = 1'b1;
        step(1);
        chk("dis_load_pend", 32'(pend), 32'd1);
        load = 1'b0;
        step(1);
        chk("dis_load_xfer", 32'(pend), 32'd0);
        enable = 1'b1;
        step(1);
        chk("reen_sync", 32'(sync), 32'd1);
        chk("reen_out", 32'(out), 32'd3);
        meas(-1, 16'd0, -1, 16'd0, len, hi0, hi1, first_low, last0, pend_prev, pend_last);
        chk("reen_len", len, 32'd255);
        chk("reen_hi0", hi0, 32'd200);

        // Reset in the middle of a period, with a load pending.
        step(30);
        level = {8'd255, 8'd50}; load = 1'b1;
        step(1);
        chk("pre_rst_pend", 32'(pend), 32'd1);
        load = 1'b0; rst = 1'b1;
        step(1);
        chk("mid_rst_out", 32'(out), 32'd0);
        chk("mid_rst_sync", 32'(sync), 32'd0);
        chk("mid_rst_pend", 32'(pend), 32'd0);
        rst = 1'b0;
        step(1);
        chk("after_rst_sync", 32'(sync), 32'd1);
        chk("after_rst_out", 32'(out), 32'd0);
        meas(-1, 16'd0, -1, 16'd0, len, hi0, hi1, first_low, last0, pend_prev, pend_last);
        chk("after_rst_len", len, 32'd255);
        chk("after_rst_hi0", hi0, 32'd0);
        chk("after_rst_hi1", hi1, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_multi.md
# pwm_multi

Multi-channel PWM generator, successor to the single-channel `pwm` block. It drives `C_CHANNELS` outputs from one shared period counter, with a programmable clock prescaler and edge- or center-aligned mode. Per-channel levels are double-buffered, so an update never produces a glitched period. It sits between the control logic that computes levels and the analogue output pins / RC filters of the design.

## Interface
- `C_CLK_FRQ`, 100000000: main clock frequency [Hz]; informational only, no logic depends on it.
- `C_LEVEL_WIDTH`, 8: level width W. Full scale is M+1 = 2^W-1.
- `C_CHANNELS`, 4: number of PWM channels N (1..32).
- `C_PRESCALE_WIDTH`, 8: width P of the prescaler reload value.

- `clk` in 1: main clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: run/stop for the counter and outputs.
- `mode` in 1: 0 = edge-aligned, 1 = center-aligned. Sampled at a period boundary only.
- `prescale` in P: counter ticks every `prescale`+1 clocks. Sampled at a period boundary only.
- `level` in N*W: channel k occupies bits [k*W +: W].
- `load` in 1: one-cycle strobe; captures all of `level` into the pending registers.
- `out` out N: registered PWM outputs.
- `sync` out 1: one-clock pulse on the first clock of each period.
- `pend` out 1: high while the pending levels have not yet been applied.

## Operation
- Let M = 2^W-2.
- **Prescaler**: `psc` counts 0..`prescale_act`. A tick occurs on the clock where `psc`==`prescale_act`, and `psc` then wraps to 0. With `prescale_act`=0, every clock is a tick.
- **Edge mode**:
  - `cnt` increments 0..M on ticks, then wraps to 0.
  - Period = (M+1) ticks.
- **Center mode**:
  - State UP: `cnt` increments on ticks. At M it dwells one tick, then moves to DOWN.
  - State DOWN: `cnt` decrements on ticks. At 0 it dwells one tick, then moves to UP.
  - Each value therefore occurs twice per period. Period = 2(M+1) ticks.
- **Channel output**: `out[k]` = `enable` AND (`cnt` < `act[k]`).
  - Duty = `act[k]`/(M+1) exactly.
  - Level 0 gives constant low. Level 2^W-1 gives constant high.
  - In center mode the high pulse is centered on the period boundary.
- **Period boundary**: the tick at which `cnt` leaves the last value of a period (edge: M→0; center: end of the 0-dwell in DOWN).
  - The next clock is the first of a new period.
  - At the boundary, latch `mode_act`←`mode` and `prescale_act`←`prescale`.
  - If `pend`, also set `act`←`pending` and clear `pend`.
- **Load**: on `load`, `pending`←`level` and `pend`←1.
  - If `load` coincides with a boundary transfer, `act` takes the previous `pending` contents and `pend` stays 1 holding the new value.
  - Back-to-back loads: the last one wins.
- **Disabled** (`enable`=0):
  - `psc`, `cnt` and the direction are held at 0/UP.
  - `out`=0 and `sync`=0.
  - `mode_act` and `prescale_act` follow their inputs every clock.
  - If `pend`, `act`←`pending` and `pend` clears on the next clock.
- **Enable rising**: the first enabled clock starts a period at `cnt`=0 and `sync` pulses.
- **Reset**: `psc`, `cnt`, `act`, `pending`, `mode_act` and `prescale_act` all go to 0; direction goes to UP.

## Timing
- Reset values: `out`=0, `sync`=0, `pend`=0.
- `out` and `sync` are registered and lag the internal `cnt` state by 1 clock.
  - `sync` is high exactly one clock per period, aligned with the first `out` sample of that period.
- `load` → `pend`=1 on the next clock.
- `pend` falls on the clock after the boundary. New levels are visible on `out` from the first sample of the following period.
- Edge period = (M+1)(`prescale`+1) clocks; center period = 2(M+1)(`prescale`+1) clocks.
- Reset takes priority over everything. Mid-period reset forces the outputs to their reset values on the next clock, with no partial pulse completion.
- `enable` falling: `out`=0 on the next clock; the current period is abandoned.

## Test plan
- **Reset**: hold `rst`=1 for 3 clocks while `enable`=1 and `load`=1 → `out`=0, `sync`=0, `pend`=0 throughout. After release, all counters start from 0.
- **Edge-mode duty**: W=8, N=2, `prescale`=0, `mode`=0; load {64, 255}; enable.
  - `sync` period = 255 clocks.
  - `out[0]` high for the first 64 clocks of each period.
  - `out[1]` constantly high.
  - A level of 0 on a channel keeps it constantly low.
- **Double buffering**: running edge mode at level 64; pulse `load` with 128 at cnt≈100.
  - The current period completes with 64 high clocks.
  - `pend` falls at the boundary.
  - The next period has 128 high clocks.
- **Center mode**: level 64, `prescale`=0, `mode`=1.
  - Period = 510 clocks.
  - `out[0]` high for the first 64 and the last 64 clocks of each period.
- **Prescaler**: `prescale`=3, edge mode, level 10 → period 1020 clocks, 40 high clocks. Changing `prescale` mid-period takes effect only at the next boundary.
- **Coincidence and disable**:
  - `load` on a boundary clock → old pending applied, `pend` stays 1, new value applied one period later.
  - Dropping `enable` mid-pulse → `out`=0 next clock.
  - Re-enabling → `sync` pulses on the first clock.
